// File: rtl/fdiv_seq.sv
// fdiv_seq: sequential single-precision divider, y = x1 / x2.
//
// Restoring division producing one quotient bit per clock, followed by a
// single round-to-nearest-even step. Subnormal operands count as zero.
// Every request takes the same number of cycles, special cases included,
// so the issue logic can count on a fixed latency.
//
// Optional feature macro: FDIV_NAN_INF_EN
//   defined   - exponent 255 is decoded as NaN/infinity
//   undefined - exponent 255 is an ordinary finite exponent
//
// Ports:
//   clk    in   sole clock, rising edge
//   rstn   in   asynchronous active-low reset
//   x1     in   dividend, sampled on the accepting edge
//   x2     in   divisor, sampled on the accepting edge
//   start  in   request, accepted on an edge where start && ready
//   ready  out  high when a request can be accepted
//   y      out  quotient, meaningful while valid is high, held afterwards
//   valid  out  one-cycle result strobe
module fdiv_seq (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        start,
  output logic        ready,
  output logic [31:0] y,
  output logic        valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [24:0]        r_q, r_d;
  logic [23:0]        mb_q, mb_d;
  logic [25:0]        quo_q, quo_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  ediff_q, ediff_d;
  logic               spec_q, spec_d;
  logic [31:0]        spec_val_q, spec_val_d;
  logic [31:0]        y_q, y_d;
  logic               valid_q, valid_d;

  // Special-case decode of the live operands, used only on the accepting edge.
  logic               spec_hit;
  logic [31:0]        spec_val;
  logic [24:0]        r_sub;
  logic               q_bit;

  // Normalise the raw quotient, round to nearest even and pack, applying
  // overflow to infinity and underflow to zero after rounding.
  function automatic logic [31:0] round_pack(
    input logic              s,
    input logic [25:0]       q,
    input logic              rem_nz,
    input logic signed [9:0] ed
  );
    logic [22:0]       man;
    logic              g;
    logic              st;
    logic signed [9:0] e;
    logic [23:0]       sum;
    if (q[25]) begin
      man = q[24:2];
      g   = q[1];
      st  = q[0] | rem_nz;
      e   = ed + 10'sd127;
    end else begin
      man = q[23:1];
      g   = q[0];
      st  = rem_nz;
      e   = ed + 10'sd126;
    end
    sum = {1'b0, man} + {23'd0, (g & (st | man[0]))};
    // An all-ones fraction rounding up wraps to 1.0 of the next binade.
    if (sum[23]) begin
      man = 23'd0;
      e   = e + 10'sd1;
    end else begin
      man = sum[22:0];
    end
    if (e <= 10'sd0) begin
      return {s, 31'd0};
    end else if (e >= 10'sd255) begin
      return {s, 8'hff, 23'd0};
    end else begin
      return {s, e[7:0], man};
    end
  endfunction

  always_comb begin
    logic       sgn;
    logic       a_zero;
    logic       b_zero;
`ifdef FDIV_NAN_INF_EN
    logic       a_nan;
    logic       b_nan;
    logic       a_inf;
    logic       b_inf;
`endif
    sgn      = x1[31] ^ x2[31];
    a_zero   = (x1[30:23] == 8'd0);
    b_zero   = (x2[30:23] == 8'd0);
    spec_hit = 1'b0;
    spec_val = 32'd0;
`ifdef FDIV_NAN_INF_EN
    a_nan = (x1[30:23] == 8'hff) && (x1[22:0] != 23'd0);
    b_nan = (x2[30:23] == 8'hff) && (x2[22:0] != 23'd0);
    a_inf = (x1[30:23] == 8'hff) && (x1[22:0] == 23'd0);
    b_inf = (x2[30:23] == 8'hff) && (x2[22:0] == 23'd0);
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
      spec_hit = 1'b1;
      spec_val = 32'h7fc00000;
    end else if (a_inf) begin
      spec_hit = 1'b1;
      spec_val = {sgn, 8'hff, 23'd0};
    end else if (b_inf) begin
      spec_hit = 1'b1;
      spec_val = {sgn, 31'd0};
    end else
`endif
    // A zero divisor wins over a zero dividend, so 0/0 lands on infinity.
    if (b_zero) begin
      spec_hit = 1'b1;
      spec_val = {sgn, 8'hff, 23'd0};
    end else if (a_zero) begin
      spec_hit = 1'b1;
      spec_val = {sgn, 31'd0};
    end
  end

  // One restoring step on the current remainder.
  assign q_bit = (r_q >= {1'b0, mb_q});
  assign r_sub = q_bit ? (r_q - {1'b0, mb_q}) : r_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    r_d        = r_q;
    mb_d       = mb_q;
    quo_d      = quo_q;
    sign_d     = sign_q;
    ediff_d    = ediff_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    y_d        = y_q;
    valid_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sign_d     = x1[31] ^ x2[31];
          ediff_d    = $signed({2'b00, x1[30:23]}) - $signed({2'b00, x2[30:23]});
          r_d        = {2'b01, x1[22:0]};
          mb_d       = {1'b1, x2[22:0]};
          quo_d      = 26'd0;
          spec_d     = spec_hit;
          spec_val_d = spec_val;
          cnt_d      = 5'd25;
          state_d    = CALC;
        end
      end
      CALC: begin
        // r_sub < mb < 2^24, so the shift never loses a set bit.
        r_d   = r_sub << 1;
        quo_d = {quo_q[24:0], q_bit};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        y_d     = spec_q ? spec_val_q : round_pack(sign_q, quo_q, (r_q != 25'd0), ediff_q);
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      r_q        <= 25'd0;
      mb_q       <= 24'd0;
      quo_q      <= 26'd0;
      sign_q     <= 1'b0;
      ediff_q    <= 10'sd0;
      spec_q     <= 1'b0;
      spec_val_q <= 32'd0;
      y_q        <= 32'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      r_q        <= r_d;
      mb_q       <= mb_d;
      quo_q      <= quo_d;
      sign_q     <= sign_d;
      ediff_q    <= ediff_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      y_q        <= y_d;
      valid_q    <= valid_d;
    end
  end

  // Ready rises in the same cycle as the valid strobe, allowing back-to-back issue.
  assign ready = (state_q == IDLE);
  assign y     = y_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_fdiv_seq.sv
// tb_fdiv_seq: self-checking bench for fdiv_seq. Expected quotients are
// queued with the accepting cycle when a request is issued and retired when
// the valid strobe appears, checking value and latency.
module tb_fdiv_seq;

  logic        clk;
  logic        rstn;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        start;
  logic        ready;
  logic [31:0] y;
  logic        valid;

  int          total;
  int          bad;
  int          cyc;
  logic [31:0] exp_q[$];
  int          acc_q[$];
  int          last_acc;

  fdiv_seq dut (
    .clk   (clk),
    .rstn  (rstn),
    .x1    (x1),
    .x2    (x2),
    .start (start),
    .ready (ready),
    .y     (y),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference quotient computed by exact integer division.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    logic       sgn;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] e8;
    longint     ma;
    longint     mb;
    longint     num;
    longint     qq;
    longint     rem;
    longint     m;
    int         e;
    logic       g;
    logic       st;
    sgn = a[31] ^ b[31];
    ea  = a[30:23];
    eb  = b[30:23];
`ifdef FDIV_NAN_INF_EN
    if ((ea == 8'hff && a[22:0] != 0) || (eb == 8'hff && b[22:0] != 0)) return 32'h7fc00000;
    if (ea == 8'hff && eb == 8'hff) return 32'h7fc00000;
    if (ea == 8'h00 && eb == 8'h00) return 32'h7fc00000;
    if (ea == 8'hff) return {sgn, 31'h7f800000};
    if (eb == 8'hff) return {sgn, 31'h0};
`endif
    if (eb == 8'h00) return {sgn, 31'h7f800000};
    if (ea == 8'h00) return {sgn, 31'h0};
    ma  = longint'({1'b1, a[22:0]});
    mb  = longint'({1'b1, b[22:0]});
    num = ma << 25;
    qq  = num / mb;
    rem = num % mb;
    e   = int'(ea) - int'(eb);
    if (qq >= (longint'(1) << 25)) begin
      m  = qq >> 2;
      g  = qq[1];
      st = qq[0] | (rem != 0);
      e  = e + 127;
    end else begin
      m  = qq >> 1;
      g  = qq[0];
      st = (rem != 0);
      e  = e + 126;
    end
    if (g && (st || m[0])) m = m + 1;
    if (m == (longint'(1) << 24)) begin
      m = longint'(1) << 23;
      e = e + 1;
    end
    if (e <= 0) return {sgn, 31'h0};
    if (e >= 255) return {sgn, 31'h7f800000};
    e8 = e[7:0];
    return {sgn, e8, m[22:0]};
  endfunction

  // Result monitor: retires the scoreboard on every valid strobe.
  initial begin
    logic prev_v;
    logic [31:0] e;
    int a;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("y", y, e);
          chk("latency", 32'(cyc - a), 32'd28);
        end
        if (prev_v) chk("valid_pulse", 32'd2, 32'd1);
      end
      prev_v = valid;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    @(negedge clk);
    x1    = a;
    x2    = b;
    start = 1'b1;
    for (int i = 0; i < 100 && !ready; i++) @(negedge clk);
    if (!ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      exp_q.push_back(e);
      acc_q.push_back(cyc);
      last_acc = cyc;
    end
    #1;
    start = 1'b0;
    x1    = $urandom;
    x2    = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] da[$];
    logic [31:0] db[$];
    logic [31:0] de[$];
    logic [31:0] ra;
    logic [31:0] rb;
    int nb;
    int acc_a;
    total = 0;
    bad   = 0;
    cyc   = 0;
    rstn  = 1'b0;
    start = 1'b0;
    x1    = 32'd0;
    x2    = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_y", y, 32'h0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    rstn = 1'b1;

    // Exact quotient with handshake timing.
    issue(32'h40c00000, 32'h40000000, 32'h40400000);
    nb = 0;
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      if (ready) nb++;
    end
    chk("ready_busy", 32'(nb), 32'd0);
    @(negedge clk);
    chk("ready_back", {31'd0, ready}, 32'd1);
    drain();
    repeat (5) @(negedge clk);
    chk("y_hold", y, 32'h40400000);

    // Directed values: rounding, range limits, zero operands.
    da = '{32'h3f800000, 32'hbf800000, 32'h3f800000, 32'h7f000000, 32'h00800000, 32'h00000000,
           32'h00000000, 32'h80000000, 32'h3fffffff};
    db = '{32'h40400000, 32'h40400000, 32'h00000000, 32'h00800000, 32'h7f000000, 32'h40000000,
           32'h00000000, 32'h40000000, 32'h3f800000};
`ifdef FDIV_NAN_INF_EN
    de = '{32'h3eaaaaab, 32'hbeaaaaab, 32'h7f800000, 32'h7f800000, 32'h00000000, 32'h00000000,
           32'h7fc00000, 32'h80000000, 32'h3fffffff};
    da.push_back(32'h7fc00000); db.push_back(32'h3f800000); de.push_back(32'h7fc00000);
    da.push_back(32'h7f800000); db.push_back(32'h7f800000); de.push_back(32'h7fc00000);
    da.push_back(32'h3f800000); db.push_back(32'h7f800000); de.push_back(32'h00000000);
    da.push_back(32'hff800000); db.push_back(32'h40000000); de.push_back(32'hff800000);
`else
    de = '{32'h3eaaaaab, 32'hbeaaaaab, 32'h7f800000, 32'h7f800000, 32'h00000000, 32'h00000000,
           32'h7f800000, 32'h80000000, 32'h3fffffff};
`endif
    foreach (da[i]) issue(da[i], db[i], de[i]);
    drain();

    // Random finite operands against the integer-division model.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      ra[30:23] = (i % 4 == 3) ? 8'($urandom_range(1, 254)) : 8'($urandom_range(100, 154));
      rb[30:23] = (i % 4 == 3) ? 8'($urandom_range(1, 254)) : 8'($urandom_range(100, 154));
      issue(ra, rb, model(ra, rb));
    end
    drain();

    // Back-to-back with start held high; operands change during the busy window.
    @(negedge clk);
    x1    = 32'h40c00000;
    x2    = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    exp_q.push_back(32'h40400000);
    acc_q.push_back(cyc);
    acc_a = cyc;
    #1;
    x1 = 32'h3f800000;
    x2 = 32'h3f800000;
    repeat (9) @(posedge clk);
    #1;
    x1 = 32'h3f800000;
    x2 = 32'h40400000;
    for (int i = 0; i < 100 && !ready; i++) @(negedge clk);
    @(posedge clk);
    exp_q.push_back(32'h3eaaaaab);
    acc_q.push_back(cyc);
    chk("b2b_gap", 32'(cyc - acc_a), 32'd28);
    #1;
    start = 1'b0;
    drain();

    // Reset in the middle of an operation.
    issue(32'h3f800000, 32'h40400000, 32'h3eaaaaab);
    repeat (10) @(posedge clk);
    #1;
    rstn = 1'b0;
    exp_q.delete();
    acc_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_valid", {31'd0, valid}, 32'd0);
      chk("rst_mid_ready", {31'd0, ready}, 32'd1);
    end
    rstn = 1'b1;
    issue(32'h40c00000, 32'h40000000, 32'h40400000);
    drain();
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
